// File: rtl/daio_subframe_rx.sv
// Subframe receiver: assembles biphase-decoded bits into audio words with V/U/C,
// parity, channel index, frame/block tracking and sticky link status.
module daio_subframe_rx #(
  parameter int DATA_W       = 20,
  parameter int NUM_CH       = 2,
  parameter int BLOCK_FRAMES = 192,
  localparam int SLOT_BITS   = DATA_W + 4,
  localparam int CH_W        = (NUM_CH > 2) ? $clog2(NUM_CH) : 1,
  localparam int FC_W        = $clog2(BLOCK_FRAMES)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              preamble_1,
  input  logic              preamble_2,
  input  logic              preamble_3,
  input  logic              carrier_loss,
  input  logic              biphase_violation,
  input  logic              status_clear,
  output logic [DATA_W-1:0] word_data,
  output logic [2:0]        word_vuc,
  output logic [CH_W-1:0]   word_ch,
  output logic              word_valid,
  output logic              parity_err,
  output logic              block_start,
  output logic              load_buff,
  output logic [FC_W-1:0]   frame_count,
  output logic              locked,
  output logic [3:0]        rx_status
);
  localparam int BC_W = $clog2(SLOT_BITS);
  localparam logic [CH_W-1:0] LAST_CH    = CH_W'(NUM_CH - 1);
  localparam logic [BC_W-1:0] LAST_BIT   = BC_W'(SLOT_BITS - 1);
  localparam logic [FC_W-1:0] LAST_FRAME = FC_W'(BLOCK_FRAMES - 1);

  typedef enum logic [1:0] {HUNT, RECV, WAIT_PRE} state_t;

  state_t          r_state, r_state_next;
  logic [CH_W-1:0] r_ch, r_ch_next;
  logic [BC_W-1:0] r_bit_cnt, r_bit_cnt_next;
  logic            r_par, r_par_next;
  logic            r_blk_pend, r_blk_pend_next;
  logic [FC_W-1:0] r_fc_next;
  logic [3:0]      r_status_next;

  // Parity bit is never stored; it only feeds the accumulator.
  logic            r_slot [SLOT_BITS-1];
  logic [SLOT_BITS-2:0] w_slot_vec;

  logic            w_open;
  logic [CH_W-1:0] w_open_ch;
  logic            w_store;
  logic [BC_W-1:0] w_store_idx;
  logic            w_done;
  logic            w_par_bad;
  logic [3:0]      w_set;

  assign locked    = (r_state != HUNT);
  assign w_par_bad = r_par ^ bit_in;

  generate
    for (genvar gi = 0; gi < SLOT_BITS - 1; gi++) begin : g_slot
      always_ff @(posedge clock) begin
        if (reset)
          r_slot[gi] <= 1'b0;
        else if (w_store && (w_store_idx == BC_W'(gi)))
          r_slot[gi] <= bit_in;
      end
      assign w_slot_vec[gi] = r_slot[gi];
    end
  endgenerate

  always_comb begin
    r_state_next    = r_state;
    r_ch_next       = r_ch;
    r_bit_cnt_next  = r_bit_cnt;
    r_par_next      = r_par;
    r_blk_pend_next = r_blk_pend;
    r_fc_next       = frame_count;
    w_open          = 1'b0;
    w_open_ch       = '0;
    w_store         = 1'b0;
    w_store_idx     = r_bit_cnt;
    w_done          = 1'b0;
    w_set           = '0;

    if (carrier_loss) begin
      w_set[0]     = 1'b1;
      r_state_next = HUNT;
    end else begin
      case (r_state)
        HUNT: begin
          if (preamble_1 || preamble_2)
            w_open = 1'b1;
        end
        RECV, WAIT_PRE: begin
          if (preamble_1 || preamble_2) begin
            w_open = 1'b1;
            if (r_state == RECV || r_ch != LAST_CH)
              w_set[3] = 1'b1;
          end else if (preamble_3) begin
            w_open = 1'b1;
            if (r_ch == LAST_CH)
              w_set[3] = 1'b1;
            else
              w_open_ch = r_ch + CH_W'(1);
            if (r_state == RECV)
              w_set[3] = 1'b1;
          end else if (bit_valid) begin
            if (r_state == RECV) begin
              w_store    = 1'b1;
              r_par_next = r_par ^ bit_in;
              if (r_bit_cnt == LAST_BIT) begin
                w_done       = 1'b1;
                r_state_next = WAIT_PRE;
              end else begin
                r_bit_cnt_next = r_bit_cnt + BC_W'(1);
              end
            end else begin
              // Bit where a preamble was due: lost framing.
              w_set[3]     = 1'b1;
              r_state_next = HUNT;
            end
          end
        end
        default: r_state_next = HUNT;
      endcase

      // A slot opening on a preamble takes a coincident bit as slot bit 0.
      if (w_open) begin
        r_state_next    = RECV;
        r_ch_next       = w_open_ch;
        r_blk_pend_next = preamble_1;
        r_bit_cnt_next  = '0;
        r_par_next      = 1'b0;
        w_store_idx     = '0;
        if (bit_valid) begin
          w_store        = 1'b1;
          r_bit_cnt_next = BC_W'(1);
          r_par_next     = bit_in;
        end
      end
    end

    if (locked && biphase_violation)
      w_set[1] = 1'b1;
    if (w_done && w_par_bad)
      w_set[2] = 1'b1;

    if (w_done && r_ch == LAST_CH)
      r_fc_next = (frame_count == LAST_FRAME) ? '0 : frame_count + FC_W'(1);
    if (w_open && preamble_1)
      r_fc_next = '0;

    r_status_next = (status_clear ? 4'b0000 : rx_status) | w_set;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= HUNT;
      r_ch        <= '0;
      r_bit_cnt   <= '0;
      r_par       <= 1'b0;
      r_blk_pend  <= 1'b0;
      frame_count <= '0;
      rx_status   <= '0;
    end else begin
      r_state     <= r_state_next;
      r_ch        <= r_ch_next;
      r_bit_cnt   <= r_bit_cnt_next;
      r_par       <= r_par_next;
      r_blk_pend  <= r_blk_pend_next;
      frame_count <= r_fc_next;
      rx_status   <= r_status_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      word_data   <= '0;
      word_vuc    <= '0;
      word_ch     <= '0;
      word_valid  <= 1'b0;
      parity_err  <= 1'b0;
      block_start <= 1'b0;
      load_buff   <= 1'b0;
    end else begin
      word_valid <= w_done;
      load_buff  <= w_done && (r_ch == LAST_CH);
      if (w_done) begin
        word_data   <= w_slot_vec[DATA_W-1:0];
        word_vuc    <= {w_slot_vec[DATA_W], w_slot_vec[DATA_W+1], w_slot_vec[DATA_W+2]};
        word_ch     <= r_ch;
        parity_err  <= w_par_bad;
        block_start <= r_blk_pend;
      end
    end
  end

endmodule

// File: tb/tb_daio_subframe_rx.sv
// Directed bench for daio_subframe_rx: a 2-channel and a 4-channel instance
// share one bit stream; expected values are hand-derived constants.
module tb_daio_subframe_rx;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic bit_valid = 1'b0, bit_in = 1'b0;
  logic preamble_1 = 1'b0, preamble_2 = 1'b0, preamble_3 = 1'b0;
  logic carrier_loss = 1'b0, biphase_violation = 1'b0, status_clear = 1'b0;

  logic [19:0] word_data;
  logic [2:0]  word_vuc;
  logic [0:0]  word_ch;
  logic        word_valid, parity_err, block_start, load_buff, locked;
  logic [7:0]  frame_count;
  logic [3:0]  rx_status;

  logic [19:0] d4_word_data;
  logic [2:0]  d4_word_vuc;
  logic [1:0]  d4_word_ch;
  logic        d4_word_valid, d4_parity_err, d4_block_start, d4_load_buff, d4_locked;
  logic [7:0]  d4_frame_count;
  logic [3:0]  d4_rx_status;

  int total = 0;
  int bad = 0;
  int wv_cnt = 0;
  int base;

  always #5 clock = ~clock;

  daio_subframe_rx #(.DATA_W(20), .NUM_CH(2), .BLOCK_FRAMES(192)) dut (
    .clock(clock), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in),
    .preamble_1(preamble_1), .preamble_2(preamble_2), .preamble_3(preamble_3),
    .carrier_loss(carrier_loss), .biphase_violation(biphase_violation),
    .status_clear(status_clear), .word_data(word_data), .word_vuc(word_vuc),
    .word_ch(word_ch), .word_valid(word_valid), .parity_err(parity_err),
    .block_start(block_start), .load_buff(load_buff), .frame_count(frame_count),
    .locked(locked), .rx_status(rx_status)
  );

  daio_subframe_rx #(.DATA_W(20), .NUM_CH(4), .BLOCK_FRAMES(192)) dut4 (
    .clock(clock), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in),
    .preamble_1(preamble_1), .preamble_2(preamble_2), .preamble_3(preamble_3),
    .carrier_loss(carrier_loss), .biphase_violation(biphase_violation),
    .status_clear(status_clear), .word_data(d4_word_data), .word_vuc(d4_word_vuc),
    .word_ch(d4_word_ch), .word_valid(d4_word_valid), .parity_err(d4_parity_err),
    .block_start(d4_block_start), .load_buff(d4_load_buff), .frame_count(d4_frame_count),
    .locked(d4_locked), .rx_status(d4_rx_status)
  );

  always @(negedge clock) if (word_valid) wv_cnt++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_pre(input int p);
    preamble_1 = (p == 1);
    preamble_2 = (p == 2);
    preamble_3 = (p == 3);
  endtask

  // One subframe: optional preamble (own cycle, or merged with bit 0), then 24 bits.
  task automatic send_slot(input int pre, input logic [19:0] d, input logic [2:0] vuc,
                           input bit bad_par, input bit merge);
    logic [23:0] s;
    s = '0;
    s[19:0]  = d;
    s[22:20] = vuc;
    s[23]    = (^s[22:0]) ^ bad_par;
    if (pre != 0 && !merge) begin
      set_pre(pre);
      tick();
      set_pre(0);
    end
    for (int k = 0; k < 24; k++) begin
      bit_valid = 1'b1;
      bit_in    = s[k];
      if (k == 0 && merge) set_pre(pre);
      tick();
      set_pre(0);
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    $display("slot pre=%0d data=%05h vuc=%b badpar=%0b -> wv=%0b ch=%0d data=%05h perr=%0b fc=%0d st=%b",
             pre, d, vuc, bad_par, word_valid, word_ch, word_data, parity_err, frame_count, rx_status);
  endtask

  task automatic send_bits(input int n);
    for (int k = 0; k < n; k++) begin
      bit_valid = 1'b1;
      bit_in    = k[0];
      tick();
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_word_valid", word_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_status", rx_status, 0);
    chk("rst_fc", frame_count, 0);

    // Basic two-channel frame opened by preamble_1
    send_slot(1, 20'h00001, 3'b000, 0, 0);
    chk("w1_valid", word_valid, 1);
    chk("w1_data", word_data, 20'h00001);
    chk("w1_ch", word_ch, 0);
    chk("w1_block", block_start, 1);
    chk("w1_perr", parity_err, 0);
    chk("w1_lb", load_buff, 0);
    chk("w1_locked", locked, 1);
    send_slot(3, 20'hABCDE, 3'b000, 0, 0);
    chk("w2_data", word_data, 20'hABCDE);
    chk("w2_ch", word_ch, 1);
    chk("w2_lb", load_buff, 1);
    chk("w2_fc", frame_count, 1);
    chk("w2_block", block_start, 0);
    tick();
    chk("w2_pulse_end", word_valid, 0);

    // Parity error, sticky status, clear
    send_slot(2, 20'h00001, 3'b000, 1, 0);
    chk("par_perr", parity_err, 1);
    chk("par_status", rx_status, 4'b0100);
    status_clear = 1'b1;
    tick();
    status_clear = 1'b0;
    chk("clr_status", rx_status, 0);
    chk("perr_held", parity_err, 1);
    send_slot(3, 20'h0F0F0, 3'b101, 0, 0);
    chk("vuc", word_vuc, 3'b101);

    // Full block: frame_count wraps at 192
    for (int f = 0; f < 192; f++) begin
      send_slot((f == 0) ? 1 : 2, 20'(f * 3 + 1), 3'b010, 0, 0);
      send_slot(3, 20'(f) ^ 20'hFFFFF, 3'b001, 0, 0);
      chk($sformatf("fc_f%0d", f), frame_count, (f + 1) % 192);
    end
    chk("wrap_status", rx_status, 0);
    send_slot(2, 20'h11111, 3'b000, 0, 0);
    send_slot(3, 20'h22222, 3'b000, 0, 0);
    chk("fc_extra", frame_count, 1);
    set_pre(1);
    tick();
    set_pre(0);
    chk("fc_forced", frame_count, 0);
    send_slot(0, 20'h33333, 3'b000, 0, 0);
    chk("p1_block", block_start, 1);
    send_slot(3, 20'h44444, 3'b000, 0, 0);
    chk("blk_status", rx_status, 0);

    // Preamble_2 after 10 bits aborts the slot
    set_pre(2);
    tick();
    set_pre(0);
    base = wv_cnt;
    send_bits(10);
    send_slot(2, 20'h76543, 3'b000, 0, 0);
    chk("abort_cnt", wv_cnt, base);
    chk("abort_wv", word_valid, 1);
    chk("abort_ch", word_ch, 0);
    chk("abort_data", word_data, 20'h76543);
    chk("abort_status", rx_status, 4'b1000);
    status_clear = 1'b1;
    tick();
    status_clear = 1'b0;

    // Carrier loss mid-slot
    set_pre(3);
    tick();
    set_pre(0);
    send_bits(5);
    carrier_loss = 1'b1;
    tick();
    carrier_loss = 1'b0;
    chk("cl_locked", locked, 0);
    chk("cl_status", rx_status, 4'b0001);
    base = wv_cnt;
    send_slot(0, 20'h12121, 3'b000, 0, 0);
    chk("cl_ignored_wv", word_valid, 0);
    chk("cl_ignored_cnt", wv_cnt, base);
    chk("cl_still_hunt", locked, 0);
    send_slot(2, 20'h5A5A5, 3'b000, 0, 0);
    chk("cl_relock_wv", word_valid, 1);
    chk("cl_relock_data", word_data, 20'h5A5A5);

    // Reset while bits stream mid-slot
    set_pre(3);
    tick();
    set_pre(0);
    send_bits(8);
    reset = 1'b1;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    tick();
    chk("mrst_data", word_data, 0);
    chk("mrst_wv", word_valid, 0);
    chk("mrst_locked", locked, 0);
    chk("mrst_status", rx_status, 0);
    chk("mrst_fc", frame_count, 0);
    chk("mrst_perr", parity_err, 0);
    reset = 1'b0;
    bit_valid = 1'b0;
    bit_in = 1'b0;
    tick();

    // Four-channel frame; first preamble coincides with bit 0
    send_slot(2, 20'h12345, 3'b000, 0, 1);
    chk("c4_0_wv", d4_word_valid, 1);
    chk("c4_0_data", d4_word_data, 20'h12345);
    chk("c4_0_ch", d4_word_ch, 0);
    chk("c4_0_lb", d4_load_buff, 0);
    send_slot(3, 20'h00011, 3'b000, 0, 0);
    chk("c4_1_ch", d4_word_ch, 1);
    chk("c4_1_lb", d4_load_buff, 0);
    send_slot(3, 20'h00022, 3'b000, 0, 0);
    chk("c4_2_ch", d4_word_ch, 2);
    chk("c4_2_lb", d4_load_buff, 0);
    send_slot(3, 20'h00033, 3'b000, 0, 0);
    chk("c4_3_ch", d4_word_ch, 3);
    chk("c4_3_lb", d4_load_buff, 1);
    chk("c4_fc", d4_frame_count, 1);
    chk("c4_status", d4_rx_status, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
